// File: rtl/femto_bus_arbiter.sv
// Two-master arbiter sharing one bus between instruction fetch and data access.
// Ties alternate between the masters; an ifetch jump discards the in-flight fetch result.
module femto_bus_arbiter #(
    parameter int ADDR_WIDTH  = 28,
    parameter int IADDR_WIDTH = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ifetch_req,
    input  logic [IADDR_WIDTH:1]   ifetch_addr,
    input  logic                   ifetch_jump,
    output logic                   ifetch_ready,
    output logic [31:0]            ifetch_data,
    input  logic [1:0]             data_read_n,
    input  logic [1:0]             data_write_n,
    input  logic [ADDR_WIDTH-1:0]  data_addr,
    input  logic [31:0]            data_wdata,
    output logic                   data_ready,
    output logic [31:0]            data_rdata,
    output logic [ADDR_WIDTH-1:0]  bus_addr,
    output logic [31:0]            bus_wdata,
    output logic [1:0]             bus_read_n,
    output logic [1:0]             bus_write_n,
    input  logic [31:0]            bus_rdata,
    input  logic                   bus_ready
);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        INSTR = 4'b0010,
        DATA  = 4'b0100,
        DRAIN = 4'b1000
    } state_t;

    localparam logic GRANT_INSTR = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;
    localparam logic [1:0] SIZE_NONE = 2'b11;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t                  state_reg, state_next;
    logic                    last_grant_reg, last_grant_next;
    logic                    pend_valid_reg, pend_valid_next;
    logic [IADDR_WIDTH:1]    pend_addr_reg, pend_addr_next;
    logic [ADDR_WIDTH-1:0]   bus_addr_reg, bus_addr_next;
    logic [31:0]             bus_wdata_reg, bus_wdata_next;
    logic [1:0]              bus_read_n_reg, bus_read_n_next;
    logic [1:0]              bus_write_n_reg, bus_write_n_next;

    logic                    data_pending;
    logic                    instr_pending;
    logic                    grant_data;
    logic                    ifetch_done;
    logic                    data_done;
    logic [IADDR_WIDTH:1]    fetch_addr_sel;
    logic [ADDR_WIDTH-1:0]   fetch_bus_addr;

    assign data_pending  = (data_read_n != SIZE_NONE) || (data_write_n != SIZE_NONE);
    assign instr_pending = ifetch_req || pend_valid_reg || ifetch_jump;
    // A jump presented this cycle outranks a previously captured jump target.
    assign fetch_addr_sel = ifetch_jump    ? ifetch_addr :
                            pend_valid_reg ? pend_addr_reg : ifetch_addr;

    // Halfword fetch address placed at bits [IADDR_WIDTH:1], zero elsewhere.
    generate
        for (genvar gi = 0; gi < ADDR_WIDTH; gi++) begin : g_fetch_addr
            if (gi >= 1 && gi <= IADDR_WIDTH) begin : g_bit
                assign fetch_bus_addr[gi] = fetch_addr_sel[gi];
            end else begin : g_zero
                assign fetch_bus_addr[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        state_next       = state_reg;
        last_grant_next  = last_grant_reg;
        pend_valid_next  = pend_valid_reg;
        pend_addr_next   = pend_addr_reg;
        bus_addr_next    = bus_addr_reg;
        bus_wdata_next   = bus_wdata_reg;
        bus_read_n_next  = bus_read_n_reg;
        bus_write_n_next = bus_write_n_reg;
        ifetch_done      = 1'b0;
        data_done        = 1'b0;
        grant_data       = 1'b0;

        // Any jump seen outside a fresh instruction grant is parked for later.
        if (ifetch_jump) begin
            pend_valid_next = 1'b1;
            pend_addr_next  = ifetch_addr;
        end

        case (state_reg)
            IDLE: begin
                grant_data = data_pending && (!instr_pending || last_grant_reg == GRANT_INSTR);
                if (grant_data) begin
                    state_next       = DATA;
                    bus_addr_next    = data_addr;
                    bus_wdata_next   = data_wdata;
                    bus_read_n_next  = data_read_n;
                    bus_write_n_next = data_write_n;
                end else if (instr_pending) begin
                    state_next       = INSTR;
                    bus_addr_next    = fetch_bus_addr;
                    bus_read_n_next  = SIZE_WORD;
                    bus_write_n_next = SIZE_NONE;
                    pend_valid_next  = 1'b0;
                end
            end
            INSTR: begin
                if (bus_ready) begin
                    ifetch_done      = !ifetch_jump;
                    last_grant_next  = GRANT_INSTR;
                    state_next       = IDLE;
                    bus_read_n_next  = SIZE_NONE;
                    bus_write_n_next = SIZE_NONE;
                end else if (ifetch_jump) begin
                    state_next = DRAIN;
                end
            end
            DATA: begin
                if (bus_ready) begin
                    data_done        = 1'b1;
                    last_grant_next  = GRANT_DATA;
                    state_next       = IDLE;
                    bus_read_n_next  = SIZE_NONE;
                    bus_write_n_next = SIZE_NONE;
                end
            end
            DRAIN: begin
                if (bus_ready) begin
                    last_grant_next  = GRANT_INSTR;
                    state_next       = IDLE;
                    bus_read_n_next  = SIZE_NONE;
                    bus_write_n_next = SIZE_NONE;
                end
            end
            default: begin
                state_next       = IDLE;
                bus_read_n_next  = SIZE_NONE;
                bus_write_n_next = SIZE_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            last_grant_reg  <= GRANT_INSTR;
            pend_valid_reg  <= 1'b0;
            pend_addr_reg   <= '0;
            bus_addr_reg    <= '0;
            bus_wdata_reg   <= '0;
            bus_read_n_reg  <= SIZE_NONE;
            bus_write_n_reg <= SIZE_NONE;
        end else begin
            state_reg       <= state_next;
            last_grant_reg  <= last_grant_next;
            pend_valid_reg  <= pend_valid_next;
            pend_addr_reg   <= pend_addr_next;
            bus_addr_reg    <= bus_addr_next;
            bus_wdata_reg   <= bus_wdata_next;
            bus_read_n_reg  <= bus_read_n_next;
            bus_write_n_reg <= bus_write_n_next;
        end
    end

    // A completion coinciding with reset is abandoned, not reported.
    assign ifetch_ready = ifetch_done && !rst;
    assign data_ready   = data_done && !rst;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_rdata
            assign ifetch_data[gi] = ifetch_ready & bus_rdata[gi];
            assign data_rdata[gi]  = data_ready & bus_rdata[gi];
        end
    endgenerate

    assign bus_addr    = bus_addr_reg;
    assign bus_wdata   = bus_wdata_reg;
    assign bus_read_n  = bus_read_n_reg;
    assign bus_write_n = bus_write_n_reg;

endmodule

// File: tb/tb_femto_bus_arbiter.sv
// Bench for femto_bus_arbiter: cycle vectors for directed scenarios, then a
// contention run whose grant order is checked against a scoreboard queue.
module tb_femto_bus_arbiter;

    localparam logic [1:0] NO = 2'b11;
    localparam logic [1:0] RW = 2'b10;
    localparam logic [1:0] BY = 2'b00;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifetch_req;
    logic [23:1] ifetch_addr;
    logic        ifetch_jump;
    logic        ifetch_ready;
    logic [31:0] ifetch_data;
    logic [1:0]  data_read_n;
    logic [1:0]  data_write_n;
    logic [27:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_ready;
    logic [31:0] data_rdata;
    logic [27:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [1:0]  bus_read_n;
    logic [1:0]  bus_write_n;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    int total = 0;
    int bad   = 0;

    femto_bus_arbiter #(.ADDR_WIDTH(28), .IADDR_WIDTH(23)) dut (
        .clk(clk), .rst(rst),
        .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr), .ifetch_jump(ifetch_jump),
        .ifetch_ready(ifetch_ready), .ifetch_data(ifetch_data),
        .data_read_n(data_read_n), .data_write_n(data_write_n),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_ready(data_ready), .data_rdata(data_rdata),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_read_n(bus_read_n), .bus_write_n(bus_write_n),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        ireq;
        logic [23:1] iaddr;
        logic        ijump;
        logic [1:0]  drd;
        logic [1:0]  dwr;
        logic [27:0] daddr;
        logic [31:0] dwd;
        logic [31:0] brd;
        logic        brdy;
        logic [129:0] exp;
    } vec_t;

    typedef struct packed {
        logic        is_data;
        logic [27:0] addr;
        logic [31:0] rdata;
    } sb_t;

    function automatic vec_t mk(
        input logic r, input logic ireq, input logic [23:1] iaddr, input logic ijump,
        input logic [1:0] drd, input logic [1:0] dwr, input logic [27:0] daddr,
        input logic [31:0] dwd, input logic [31:0] brd, input logic brdy,
        input logic [27:0] e_ba, input logic [1:0] e_rn, input logic [1:0] e_wn,
        input logic [31:0] e_wd, input logic e_ir, input logic [31:0] e_id,
        input logic e_dr, input logic [31:0] e_dd);
        vec_t v;
        v.rst = r; v.ireq = ireq; v.iaddr = iaddr; v.ijump = ijump;
        v.drd = drd; v.dwr = dwr; v.daddr = daddr; v.dwd = dwd;
        v.brd = brd; v.brdy = brdy;
        v.exp = {e_ba, e_rn, e_wn, e_wd, e_ir, e_id, e_dr, e_dd};
        return v;
    endfunction

    vec_t vq[$];
    sb_t  exp_q[$];

    initial begin
        logic [129:0] got;
        sb_t cur;
        int ni, nd, busy, cyc;
        logic act, prev_act;
        logic [65:0] got_r, exp_r;

        rst = 1'b1; ifetch_req = 1'b0; ifetch_addr = '0; ifetch_jump = 1'b0;
        data_read_n = NO; data_write_n = NO; data_addr = '0; data_wdata = '0;
        bus_rdata = '0; bus_ready = 1'b0;
        repeat (2) @(posedge clk);

        // fetch only, ready on the third bus cycle
        vq.push_back(mk(1'b1,1'b0,23'h0,1'b0,NO,NO,28'h0,32'h0,32'h0,1'b0, 28'h0,NO,NO,32'h0,1'b0,32'h0,1'b0,32'h0));
        vq.push_back(mk(1'b0,1'b1,23'h10,1'b0,NO,NO,28'h0,32'h0,32'h0,1'b0, 28'h0,NO,NO,32'h0,1'b0,32'h0,1'b0,32'h0));
        vq.push_back(mk(1'b0,1'b1,23'h10,1'b0,NO,NO,28'h0,32'h0,32'h0,1'b0, 28'h20,RW,NO,32'h0,1'b0,32'h0,1'b0,32'h0));
        vq.push_back(mk(1'b0,1'b1,23'h10,1'b0,NO,NO,28'h0,32'h0,32'h0,1'b0, 28'h20,RW,NO,32'h0,1'b0,32'h0,1'b0,32'h0));
        vq.push_back(mk(1'b0,1'b1,23'h10,1'b0,NO,NO,28'h0,32'h0,32'h00500093,1'b1, 28'h20,RW,NO,32'h0,1'b1,32'h00500093,1'b0,32'h0));
        vq.push_back(mk(1'b0,1'b0,23'h10,1'b0,NO,NO,28'h0,32'h0,32'h0,1'b0, 28'h20,NO,NO,32'h0,1'b0,32'h0,1'b0,32'h0));
        // reset, then simultaneous load and fetch: data first
        vq.push_back(mk(1'b1,1'b0,23'h0,1'b0,NO,NO,28'h0,32'h0,32'h0,1'b0, 28'h20,NO,NO,32'h0,1'b0,32'h0,1'b0,32'h0));
        vq.push_back(mk(1'b0,1'b1,23'h2,1'b0,RW,NO,28'h1000004,32'h0,32'h0,1'b0, 28'h0,NO,NO,32'h0,1'b0,32'h0,1'b0,32'h0));
        vq.push_back(mk(1'b0,1'b1,23'h2,1'b0,RW,NO,28'h1000004,32'h0,32'hDEADBEEF,1'b1, 28'h1000004,RW,NO,32'h0,1'b0,32'h0,1'b1,32'hDEADBEEF));
        vq.push_back(mk(1'b0,1'b1,23'h2,1'b0,NO,NO,28'h0,32'h0,32'h0,1'b0, 28'h1000004,NO,NO,32'h0,1'b0,32'h0,1'b0,32'h0));
        vq.push_back(mk(1'b0,1'b1,23'h2,1'b0,NO,NO,28'h0,32'h0,32'h12345678,1'b1, 28'h4,RW,NO,32'h0,1'b1,32'h12345678,1'b0,32'h0));
        vq.push_back(mk(1'b0,1'b0,23'h0,1'b0,NO,NO,28'h0,32'h0,32'h0,1'b0, 28'h4,NO,NO,32'h0,1'b0,32'h0,1'b0,32'h0));
        // byte store 0xA5 to 0x8000001
        vq.push_back(mk(1'b0,1'b0,23'h0,1'b0,NO,BY,28'h8000001,32'hA5,32'h0,1'b0, 28'h4,NO,NO,32'h0,1'b0,32'h0,1'b0,32'h0));
        vq.push_back(mk(1'b0,1'b0,23'h0,1'b0,NO,BY,28'h8000001,32'hA5,32'h0,1'b0, 28'h8000001,NO,BY,32'hA5,1'b0,32'h0,1'b0,32'h0));
        vq.push_back(mk(1'b0,1'b0,23'h0,1'b0,NO,BY,28'h8000001,32'hA5,32'h0,1'b1, 28'h8000001,NO,BY,32'hA5,1'b0,32'h0,1'b1,32'h0));
        vq.push_back(mk(1'b0,1'b0,23'h0,1'b0,NO,NO,28'h0,32'h0,32'h0,1'b0, 28'h8000001,NO,NO,32'hA5,1'b0,32'h0,1'b0,32'h0));
        // jump one cycle before bus_ready: drain, then refetch
        vq.push_back(mk(1'b0,1'b1,23'h40,1'b0,NO,NO,28'h0,32'h0,32'h0,1'b0, 28'h8000001,NO,NO,32'hA5,1'b0,32'h0,1'b0,32'h0));
        vq.push_back(mk(1'b0,1'b1,23'h40,1'b0,NO,NO,28'h0,32'h0,32'h0,1'b0, 28'h80,RW,NO,32'hA5,1'b0,32'h0,1'b0,32'h0));
        vq.push_back(mk(1'b0,1'b1,23'h100,1'b1,NO,NO,28'h0,32'h0,32'h0,1'b0, 28'h80,RW,NO,32'hA5,1'b0,32'h0,1'b0,32'h0));
        vq.push_back(mk(1'b0,1'b1,23'h100,1'b0,NO,NO,28'h0,32'h0,32'hBAD0BAD0,1'b1, 28'h80,RW,NO,32'hA5,1'b0,32'h0,1'b0,32'h0));
        vq.push_back(mk(1'b0,1'b1,23'h100,1'b0,NO,NO,28'h0,32'h0,32'h0,1'b0, 28'h80,NO,NO,32'hA5,1'b0,32'h0,1'b0,32'h0));
        vq.push_back(mk(1'b0,1'b1,23'h100,1'b0,NO,NO,28'h0,32'h0,32'h13,1'b1, 28'h200,RW,NO,32'hA5,1'b1,32'h13,1'b0,32'h0));
        vq.push_back(mk(1'b0,1'b0,23'h0,1'b0,NO,NO,28'h0,32'h0,32'h0,1'b0, 28'h200,NO,NO,32'hA5,1'b0,32'h0,1'b0,32'h0));
        // reset during a data read; late bus_ready must be ignored
        vq.push_back(mk(1'b0,1'b0,23'h0,1'b0,RW,NO,28'h100,32'h11112222,32'h0,1'b0, 28'h200,NO,NO,32'hA5,1'b0,32'h0,1'b0,32'h0));
        vq.push_back(mk(1'b0,1'b0,23'h0,1'b0,RW,NO,28'h100,32'h11112222,32'h0,1'b0, 28'h100,RW,NO,32'h11112222,1'b0,32'h0,1'b0,32'h0));
        vq.push_back(mk(1'b1,1'b0,23'h0,1'b0,RW,NO,28'h100,32'h11112222,32'h0,1'b0, 28'h100,RW,NO,32'h11112222,1'b0,32'h0,1'b0,32'h0));
        vq.push_back(mk(1'b0,1'b0,23'h0,1'b0,NO,NO,28'h0,32'h0,32'hCAFEF00D,1'b1, 28'h0,NO,NO,32'h0,1'b0,32'h0,1'b0,32'h0));
        vq.push_back(mk(1'b0,1'b0,23'h0,1'b0,RW,NO,28'h200,32'h0,32'h0,1'b0, 28'h0,NO,NO,32'h0,1'b0,32'h0,1'b0,32'h0));
        vq.push_back(mk(1'b0,1'b0,23'h0,1'b0,RW,NO,28'h200,32'h0,32'h55AA55AA,1'b1, 28'h200,RW,NO,32'h0,1'b0,32'h0,1'b1,32'h55AA55AA));
        vq.push_back(mk(1'b0,1'b0,23'h0,1'b0,NO,NO,28'h0,32'h0,32'h0,1'b0, 28'h200,NO,NO,32'h0,1'b0,32'h0,1'b0,32'h0));
        // jump coinciding with bus_ready: stale word dropped
        vq.push_back(mk(1'b0,1'b1,23'h8,1'b0,NO,NO,28'h0,32'h0,32'h0,1'b0, 28'h200,NO,NO,32'h0,1'b0,32'h0,1'b0,32'h0));
        vq.push_back(mk(1'b0,1'b1,23'h20,1'b1,NO,NO,28'h0,32'h0,32'h77,1'b1, 28'h10,RW,NO,32'h0,1'b0,32'h0,1'b0,32'h0));
        vq.push_back(mk(1'b0,1'b1,23'h20,1'b0,NO,NO,28'h0,32'h0,32'h0,1'b0, 28'h10,NO,NO,32'h0,1'b0,32'h0,1'b0,32'h0));
        vq.push_back(mk(1'b0,1'b1,23'h20,1'b0,NO,NO,28'h0,32'h0,32'h99,1'b1, 28'h40,RW,NO,32'h0,1'b1,32'h99,1'b0,32'h0));
        vq.push_back(mk(1'b0,1'b0,23'h0,1'b0,NO,NO,28'h0,32'h0,32'h0,1'b0, 28'h40,NO,NO,32'h0,1'b0,32'h0,1'b0,32'h0));

        foreach (vq[i]) begin
            @(posedge clk); #1;
            rst = vq[i].rst; ifetch_req = vq[i].ireq; ifetch_addr = vq[i].iaddr;
            ifetch_jump = vq[i].ijump; data_read_n = vq[i].drd; data_write_n = vq[i].dwr;
            data_addr = vq[i].daddr; data_wdata = vq[i].dwd;
            bus_rdata = vq[i].brd; bus_ready = vq[i].brdy;
            @(negedge clk);
            got = {bus_addr, bus_read_n, bus_write_n, bus_wdata, ifetch_ready, ifetch_data, data_ready, data_rdata};
            total++;
            if (got !== vq[i].exp) begin
                bad++;
                $display("FAIL vec%0d got=%h exp=%h", i, got, vq[i].exp);
            end else begin
                $display("vec%0d bus_addr=%h rn=%b wn=%b ir=%b dr=%b", i, bus_addr, bus_read_n, bus_write_n, ifetch_ready, data_ready);
            end
        end

        // continuous contention: data, instr, data, instr, data, instr
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back('{1'b1, 28'(32'h8000000 + 4 * k), 32'({4'h0, 28'(32'h8000000 + 4 * k)}) ^ 32'h5A5A0000});
            exp_q.push_back('{1'b0, 28'(32'h600 + 2 * k), 32'({4'h0, 28'(32'h600 + 2 * k)}) ^ 32'h5A5A0000});
        end
        ni = 0; nd = 0; busy = 0; cyc = 0; prev_act = 1'b0; cur = '0;
        while ((ni < 3 || nd < 3) && cyc < 300) begin
            @(posedge clk); #1;
            ifetch_req   = (ni < 3);
            ifetch_addr  = 23'(32'h300 + ni);
            ifetch_jump  = 1'b0;
            data_read_n  = (nd < 3) ? RW : NO;
            data_write_n = NO;
            data_addr    = 28'(32'h8000000 + 4 * nd);
            bus_ready    = (busy >= 2);
            bus_rdata    = {4'h0, bus_addr} ^ 32'h5A5A0000;
            @(negedge clk);
            cyc++;
            act = (bus_read_n != NO) || (bus_write_n != NO);
            if (act && !prev_act) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL grant_extra addr=%h", bus_addr);
                end else begin
                    cur = exp_q.pop_front();
                    if (bus_addr !== cur.addr || bus_read_n !== RW) begin
                        bad++;
                        $display("FAIL grant got addr=%h rn=%b exp addr=%h rn=%b", bus_addr, bus_read_n, cur.addr, RW);
                    end else begin
                        $display("grant %s addr=%h", cur.is_data ? "data" : "instr", bus_addr);
                    end
                end
            end
            if (ifetch_ready || data_ready) begin
                got_r = {ifetch_ready, data_ready, ifetch_data, data_rdata};
                exp_r = {!cur.is_data, cur.is_data, cur.is_data ? 32'h0 : cur.rdata, cur.is_data ? cur.rdata : 32'h0};
                total++;
                if (got_r !== exp_r) begin
                    bad++;
                    $display("FAIL ready got=%h exp=%h", got_r, exp_r);
                end else begin
                    $display("ready %s data=%h", cur.is_data ? "data" : "instr", cur.rdata);
                end
                if (ifetch_ready) ni++;
                if (data_ready) nd++;
                busy = 0;
            end else if (act) begin
                busy++;
            end else begin
                busy = 0;
            end
            prev_act = act;
        end
        total++;
        if (ni < 3 || nd < 3 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL contention_done got ni=%0d nd=%0d left=%0d exp ni=3 nd=3 left=0", ni, nd, exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
